// File: rtl/mac_pkg.sv
// Shared widths and FSM encoding for the MAC datapath front end.
package mac_pkg;
  localparam int unsigned NX    = 18;
  localparam int unsigned NA    = 36;
  localparam int unsigned NI    = 6;
  localparam int unsigned DEPTH = 2 ** NI;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;
endpackage

// File: rtl/coef_regfile.sv
// DEPTH x W register file: one synchronous write port, one asynchronous read port.
module coef_regfile
  import mac_pkg::*;
#(
  parameter int unsigned W = NA
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [NI-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [NI-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mac_feeder.sv
// Feeds the MAC: circular sample history plus coefficient file, read by tap index,
// with a one-sample-per-run handshake and a single-cycle start pulse.
module mac_feeder
  import mac_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          smp_valid_i,
  input  logic [NX-1:0] smp_i,
  output logic          smp_ready_o,
  input  logic          coef_we_i,
  input  logic [NI-1:0] coef_addr_i,
  input  logic [NA-1:0] coef_i,
  input  logic [NI-1:0] i_i,
  input  logic          eof_i,
  output logic          stf_o,
  output logic [NX-1:0] x_o,
  output logic [NA-1:0] a_o,
  output logic [NI:0]   fill_o
);

  state_e        state_q;
  logic [NI-1:0] head_q, head_d;
  logic [NI:0]   fill_q, fill_d;
  logic          stf_q;
  logic          ready_q;
  logic          accept_c;
  logic          coef_we_c;
  logic [NI-1:0] hist_raddr_c;

  assign accept_c     = (state_q == ST_IDLE) && smp_valid_i;
  assign coef_we_c    = (state_q == ST_IDLE) && coef_we_i;
  assign head_d       = head_q + NI'(1);
  assign fill_d       = (fill_q == (NI+1)'(DEPTH)) ? fill_q : fill_q + (NI+1)'(1);
  // Newest sample lives at head; older taps step backwards with wrap.
  assign hist_raddr_c = head_q - i_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      head_q  <= '0;
      fill_q  <= '0;
      stf_q   <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (smp_valid_i) begin
            head_q  <= head_d;
            fill_q  <= fill_d;
            state_q <= ST_START;
            stf_q   <= 1'b1;
            ready_q <= 1'b0;
          end
        end
        ST_START: begin
          state_q <= ST_WAIT;
          stf_q   <= 1'b0;
        end
        ST_WAIT: begin
          if (eof_i) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          stf_q   <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  coef_regfile #(.W(NX)) u_hist (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (accept_c),
    .waddr_i (head_d),
    .wdata_i (smp_i),
    .raddr_i (hist_raddr_c),
    .rdata_o (x_o)
  );

  coef_regfile #(.W(NA)) u_coef (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (coef_we_c),
    .waddr_i (coef_addr_i),
    .wdata_i (coef_i),
    .raddr_i (i_i),
    .rdata_o (a_o)
  );

  assign stf_o       = stf_q;
  assign smp_ready_o = ready_q;
  assign fill_o      = fill_q;

endmodule

// File: tb/tb_mac_feeder.sv
// Directed plus randomized bench for mac_feeder against a queue-based history model.
module tb_mac_feeder;
  import mac_pkg::*;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          smp_valid_i = 1'b0;
  logic [NX-1:0] smp_i = '0;
  logic          smp_ready_o;
  logic          coef_we_i = 1'b0;
  logic [NI-1:0] coef_addr_i = '0;
  logic [NA-1:0] coef_i = '0;
  logic [NI-1:0] i_i = '0;
  logic          eof_i = 1'b0;
  logic          stf_o;
  logic [NX-1:0] x_o;
  logic [NA-1:0] a_o;
  logic [NI:0]   fill_o;

  int tests = 0;
  int fails = 0;

  // Model: newest-first list of samples (max DEPTH) and coefficient array.
  longint hist_m[$];
  longint coef_m[DEPTH];

  always #5 clk_i = ~clk_i;

  mac_feeder dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .smp_valid_i (smp_valid_i),
    .smp_i       (smp_i),
    .smp_ready_o (smp_ready_o),
    .coef_we_i   (coef_we_i),
    .coef_addr_i (coef_addr_i),
    .coef_i      (coef_i),
    .i_i         (i_i),
    .eof_i       (eof_i),
    .stf_o       (stf_o),
    .x_o         (x_o),
    .a_o         (a_o),
    .fill_o      (fill_o)
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint exp_x(input int i);
    return (i < hist_m.size()) ? hist_m[i] : 64'sd0;
  endfunction

  task automatic model_clear();
    hist_m.delete();
    for (int k = 0; k < DEPTH; k++) coef_m[k] = 0;
  endtask

  task automatic model_push(input longint v);
    hist_m.push_front(v);
    if (hist_m.size() > DEPTH) void'(hist_m.pop_back());
  endtask

  task automatic write_coef(input int addr, input longint v);
    coef_we_i = 1'b1; coef_addr_i = NI'(addr); coef_i = NA'(v);
    @(posedge clk_i); #1;
    coef_we_i = 1'b0;
    coef_m[addr] = v;
  endtask

  // Accept one sample from IDLE and step through START into WAIT.
  task automatic start_run(input longint v);
    smp_valid_i = 1'b1; smp_i = NX'(v);
    @(posedge clk_i); #1;
    smp_valid_i = 1'b0;
    model_push(v);
    chk("stf_high", longint'(stf_o), 1);
    chk("ready_low", longint'(smp_ready_o), 0);
    @(posedge clk_i); #1;
    chk("stf_low", longint'(stf_o), 0);
  endtask

  task automatic end_run();
    eof_i = 1'b1;
    @(posedge clk_i); #1;
    eof_i = 1'b0;
    chk("ready_after_eof", longint'(smp_ready_o), 1);
  endtask

  task automatic check_tap(input int i);
    i_i = NI'(i); #1;
    chk($sformatf("x_tap%0d", i), longint'($signed(x_o)), exp_x(i));
    chk($sformatf("a_tap%0d", i), longint'($signed(a_o)), coef_m[i]);
  endtask

  task automatic check_fill();
    chk("fill", longint'(fill_o), longint'(hist_m.size()));
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    model_clear();
  endtask

  initial begin
    model_clear();
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;

    // Reset state
    chk("rst_ready", longint'(smp_ready_o), 1);
    chk("rst_stf", longint'(stf_o), 0);
    chk("rst_fill", longint'(fill_o), 0);
    check_tap(0);

    // Single run
    write_coef(0, 3); write_coef(1, 2); write_coef(2, 1);
    start_run(5);
    check_tap(0); check_tap(1); check_tap(2);
    check_fill();

    // Handshake: valid held and coef write during WAIT are ignored
    smp_valid_i = 1'b1; smp_i = NX'(99);
    coef_we_i = 1'b1; coef_addr_i = '0; coef_i = NA'(77);
    repeat (3) begin
      @(posedge clk_i); #1;
      chk("wait_ready", longint'(smp_ready_o), 0);
      chk("wait_stf", longint'(stf_o), 0);
    end
    coef_we_i = 1'b0;
    check_fill();
    check_tap(0);
    eof_i = 1'b1;
    @(posedge clk_i); #1;
    eof_i = 1'b0;
    chk("eof_ready", longint'(smp_ready_o), 1);
    check_fill();
    @(posedge clk_i); #1;
    smp_valid_i = 1'b0;
    model_push(99);
    chk("late_accept_stf", longint'(stf_o), 1);
    check_fill();
    check_tap(0); check_tap(1);
    @(posedge clk_i); #1;
    chk("late_stf_low", longint'(stf_o), 0);

    // Reset mid-WAIT clears everything
    #2 rst_i = 1'b1;
    #1;
    chk("midrst_stf", longint'(stf_o), 0);
    chk("midrst_ready", longint'(smp_ready_o), 1);
    chk("midrst_fill", longint'(fill_o), 0);
    model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      i_i = NI'(i); #1;
      chk("midrst_x", longint'($signed(x_o)), 0);
    end
    @(posedge clk_i); #1 rst_i = 1'b0;

    // History order
    start_run(10); end_run();
    start_run(20); end_run();
    start_run(30);
    check_tap(0); check_tap(1); check_tap(2); check_tap(3);
    end_run();

    // Simultaneous sample accept and coef write
    smp_valid_i = 1'b1; smp_i = NX'(40);
    coef_we_i = 1'b1; coef_addr_i = NI'(4); coef_i = NA'(-7);
    @(posedge clk_i); #1;
    smp_valid_i = 1'b0; coef_we_i = 1'b0;
    model_push(40); coef_m[4] = -7;
    chk("sim_stf", longint'(stf_o), 1);
    @(posedge clk_i); #1;
    check_tap(4); check_tap(0);
    end_run();

    // Wrap and fill saturation
    do_reset();
    for (int v = 1; v <= 70; v++) begin
      start_run(longint'(v));
      end_run();
    end
    chk("wrap_fill", longint'(fill_o), 64);
    check_tap(0); check_tap(63); check_tap(1);

    // Randomized runs
    do_reset();
    for (int r = 0; r < 40; r++) begin
      int nw;
      longint sv;
      nw = int'($urandom_range(0, 2));
      for (int w = 0; w < nw; w++)
        write_coef(int'($urandom_range(0, DEPTH - 1)), longint'($signed($urandom)));
      sv = longint'($urandom_range(0, (1 << NX) - 1)) - longint'(1 << (NX - 1));
      start_run(sv);
      check_fill();
      for (int t = 0; t < 3; t++) check_tap(int'($urandom_range(0, DEPTH - 1)));
      check_tap(0);
      end_run();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
